// File: rtl/route_controller.sv
// Line-follower route sequencer: sensor sync, follow/cross/turn FSM,
// per-motor drive commands and route progress across crossings.
module route_controller #(
  parameter int ROUTE_LEN = 4,
  parameter logic [2*ROUTE_LEN-1:0] ROUTE = 8'b11_10_01_00,
  parameter int CROSS_PERIODS = 5,
  parameter int TURN_MIN_PERIODS = 10,
  parameter int LOST_PERIODS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_l,
  input  logic       sensor_m,
  input  logic       sensor_r,
  input  logic       period_tick,
  output logic [1:0] motor_l_cmd,
  output logic [1:0] motor_r_cmd,
  output logic [3:0] route_idx,
  output logic       lost,
  output logic       done
);

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] FWD  = 2'b01;
  localparam logic [1:0] BACK = 2'b10;

  localparam logic [31:0] ROUTE_PAD = 32'(ROUTE);
  localparam logic [4:0]  LEN       = 5'(ROUTE_LEN);
  localparam logic [7:0]  CROSS_N   = 8'(CROSS_PERIODS);
  localparam logic [7:0]  TURN_N    = 8'(TURN_MIN_PERIODS);
  localparam logic [7:0]  LOST_N    = 8'(LOST_PERIODS);

  typedef enum logic [2:0] {
    FOLLOW, CROSS, TURN_L, TURN_R, LOST, DONE
  } state_t;

  state_t     state, nstate;
  logic [2:0] sync1, s;
  logic [7:0] cnt, cnt_inc, ncnt;
  logic [4:0] idx, nidx;
  logic [1:0] entry, nentry, cur_entry;
  logic [1:0] nl, nr;
  logic       cross_hit;

  assign route_idx = idx[3:0];
  assign cur_entry = ROUTE_PAD[{idx[3:0], 1'b0} +: 2];
  assign cnt_inc   = (period_tick && cnt != 8'hff) ? cnt + 8'd1 : cnt;

  always_comb begin
    nstate    = state;
    ncnt      = cnt_inc;
    nidx      = idx;
    nentry    = entry;
    cross_hit = 1'b0;
    unique case (state)
      FOLLOW: begin
        if (s == 3'b111)
          cross_hit = 1'b1;
        else if (s != 3'b000)
          ncnt = 8'd0;
        else if (period_tick && cnt_inc == LOST_N)
          nstate = LOST;
      end
      CROSS: begin
        if (period_tick && cnt_inc == CROSS_N) begin
          unique case (entry)
            2'b01:   nstate = TURN_L;
            2'b10:   nstate = TURN_R;
            default: nstate = FOLLOW;
          endcase
        end
      end
      TURN_L, TURN_R: begin
        if (cnt_inc >= TURN_N && s[1])
          nstate = FOLLOW;
      end
      LOST: begin
        if (s == 3'b111)
          cross_hit = 1'b1;
        else if (s != 3'b000)
          nstate = FOLLOW;
      end
      DONE: ;
      default: nstate = FOLLOW;
    endcase
    // Route bookkeeping shared by FOLLOW and LOST crossings
    if (cross_hit) begin
      nidx = (idx == LEN) ? idx : idx + 5'd1;
      if (idx == LEN || cur_entry == 2'b11) begin
        nstate = DONE;
      end else begin
        nstate = CROSS;
        nentry = cur_entry;
      end
    end
    if (nstate != state)
      ncnt = 8'd0;
  end

  always_comb begin
    nl = motor_l_cmd;
    nr = motor_r_cmd;
    unique case (nstate)
      FOLLOW: begin
        unique case (s)
          3'b110:  begin nl = STOP; nr = FWD;  end
          3'b100:  begin nl = BACK; nr = FWD;  end
          3'b011:  begin nl = FWD;  nr = STOP; end
          3'b001:  begin nl = FWD;  nr = BACK; end
          3'b000:  ;
          default: begin nl = FWD;  nr = FWD;  end
        endcase
      end
      CROSS:   begin nl = FWD;  nr = FWD;  end
      TURN_L:  begin nl = BACK; nr = FWD;  end
      TURN_R:  begin nl = FWD;  nr = BACK; end
      default: begin nl = STOP; nr = STOP; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 3'b000;
      s           <= 3'b000;
      state       <= FOLLOW;
      cnt         <= 8'd0;
      idx         <= 5'd0;
      entry       <= 2'b00;
      motor_l_cmd <= STOP;
      motor_r_cmd <= STOP;
      lost        <= 1'b0;
      done        <= 1'b0;
    end else begin
      sync1       <= {sensor_l, sensor_m, sensor_r};
      s           <= sync1;
      state       <= nstate;
      cnt         <= ncnt;
      idx         <= nidx;
      entry       <= nentry;
      motor_l_cmd <= nl;
      motor_r_cmd <= nr;
      lost        <= (nstate == LOST);
      done        <= (nstate == DONE);
    end
  end

endmodule

// File: tb/tb_route_controller.sv
// Scoreboard bench for route_controller: expectations are queued with a
// due cycle when stimulus is driven and compared when that cycle arrives.
module tb_route_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_l = 1'b0, sensor_m = 1'b0, sensor_r = 1'b0;
  logic       period_tick = 1'b0;
  logic [1:0] motor_l_cmd, motor_r_cmd;
  logic [3:0] route_idx;
  logic       lost, done;

  route_controller dut (
    .clk(clk), .reset(reset),
    .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r),
    .period_tick(period_tick),
    .motor_l_cmd(motor_l_cmd), .motor_r_cmd(motor_r_cmd),
    .route_idx(route_idx), .lost(lost), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      tag;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  localparam logic [1:0] ST = 2'b00, FW = 2'b01, BK = 2'b10;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic [1:0] l, input logic [1:0] r,
                                    input logic [3:0] i, input logic lo,
                                    input logic d);
    return {l, r, i, lo, d};
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag,
              {motor_l_cmd, motor_r_cmd, route_idx, lost, done}, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input string tag,
                           input logic [9:0] v);
    exp_t e;
    e.due = cyc + dly;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [2:0] v);
    {sensor_l, sensor_m, sensor_r} = v;
  endtask

  task automatic ticks(input int n, input string tag, input logic [9:0] v);
    for (int k = 0; k < n; k++) begin
      period_tick = 1'b1;
      step(1);
      period_tick = 1'b0;
      expect_at(0, tag, v);
      step(3);
    end
  endtask

  task automatic crossing(input string tag, input logic [9:0] v);
    set_s(3'b111);
    expect_at(3, tag, v);
    step(2);
    set_s(3'b000);
    step(3);
  endtask

  logic [2:0] pats [6] = '{3'b010, 3'b110, 3'b100, 3'b011, 3'b001, 3'b101};
  logic [3:0] cmds [6] = '{{FW, FW}, {ST, FW}, {BK, FW},
                           {FW, ST}, {FW, BK}, {FW, FW}};

  initial begin
    logic [3:0] prev;
    #1;
    step(9);
    expect_at(0, "reset", ev(ST, ST, 0, 0, 0));
    step(1);
    reset = 1'b0;
    step(2);

    prev = {ST, ST};
    for (int i = 0; i < 6; i++) begin
      set_s(pats[i]);
      expect_at(2, "follow_hold", ev(prev[3:2], prev[1:0], 0, 0, 0));
      expect_at(3, "follow_map", ev(cmds[i][3:2], cmds[i][1:0], 0, 0, 0));
      prev = cmds[i];
      step(20);
    end

    set_s(3'b111);
    expect_at(3, "cross1", ev(FW, FW, 1, 0, 0));
    step(2);
    set_s(3'b010);
    step(3);
    ticks(4, "cross1_run", ev(FW, FW, 1, 0, 0));
    set_s(3'b110);
    step(3);
    expect_at(0, "cross1_ignore", ev(FW, FW, 1, 0, 0));
    ticks(1, "cross1_exit", ev(ST, FW, 1, 0, 0));
    set_s(3'b010);
    step(3);

    crossing("cross2", ev(FW, FW, 2, 0, 0));
    ticks(4, "cross2_run", ev(FW, FW, 2, 0, 0));
    ticks(1, "turnl_enter", ev(BK, FW, 2, 0, 0));
    ticks(3, "turnl_run", ev(BK, FW, 2, 0, 0));
    set_s(3'b010);
    ticks(5, "turnl_min", ev(BK, FW, 2, 0, 0));
    ticks(1, "turnl_tick9", ev(BK, FW, 2, 0, 0));
    ticks(1, "turnl_exit", ev(FW, FW, 2, 0, 0));

    crossing("cross3", ev(FW, FW, 3, 0, 0));
    ticks(4, "cross3_run", ev(FW, FW, 3, 0, 0));
    ticks(1, "turnr_enter", ev(FW, BK, 3, 0, 0));
    set_s(3'b010);
    ticks(8, "turnr_run", ev(FW, BK, 3, 0, 0));
    ticks(1, "turnr_tick9", ev(FW, BK, 3, 0, 0));
    ticks(1, "turnr_exit", ev(FW, FW, 3, 0, 0));

    crossing("route_end", ev(ST, ST, 4, 0, 1));
    set_s(3'b010);
    step(4);
    expect_at(0, "done_010", ev(ST, ST, 4, 0, 1));
    crossing("done_111", ev(ST, ST, 4, 0, 1));
    ticks(3, "done_ticks", ev(ST, ST, 4, 0, 1));

    reset = 1'b1;
    set_s(3'b000);
    expect_at(0, "reset_done", ev(ST, ST, 0, 0, 0));
    step(3);
    reset = 1'b0;
    step(2);
    set_s(3'b011);
    expect_at(3, "lost_pre", ev(FW, ST, 0, 0, 0));
    step(5);
    set_s(3'b000);
    step(3);
    ticks(1, "lost_hold1", ev(FW, ST, 0, 0, 0));
    ticks(23, "lost_hold24", ev(FW, ST, 0, 0, 0));
    ticks(1, "lost_enter", ev(ST, ST, 0, 1, 0));
    set_s(3'b001);
    expect_at(2, "lost_stay", ev(ST, ST, 0, 1, 0));
    expect_at(3, "lost_exit", ev(FW, BK, 0, 0, 0));
    step(5);

    crossing("rst_c1", ev(FW, FW, 1, 0, 0));
    ticks(5, "rst_c1_run", ev(FW, FW, 1, 0, 0));
    crossing("rst_c2", ev(FW, FW, 2, 0, 0));
    ticks(4, "rst_c2_run", ev(FW, FW, 2, 0, 0));
    ticks(1, "rst_turnl", ev(BK, FW, 2, 0, 0));
    set_s(3'b010);
    ticks(9, "rst_turnl_run", ev(BK, FW, 2, 0, 0));
    ticks(1, "rst_turnl_exit", ev(FW, FW, 2, 0, 0));
    crossing("rst_c3", ev(FW, FW, 3, 0, 0));
    ticks(4, "rst_c3_run", ev(FW, FW, 3, 0, 0));
    ticks(1, "rst_turnr", ev(FW, BK, 3, 0, 0));
    ticks(2, "rst_turnr_run", ev(FW, BK, 3, 0, 0));
    reset = 1'b1;
    expect_at(0, "reset_mid_turn", ev(ST, ST, 0, 0, 0));
    step(2);
    reset = 1'b0;
    step(2);
    crossing("restart_c", ev(FW, FW, 1, 0, 0));
    ticks(4, "restart_run", ev(FW, FW, 1, 0, 0));
    ticks(1, "restart_straight", ev(FW, FW, 1, 0, 0));
    set_s(3'b110);
    expect_at(3, "restart_follow", ev(ST, FW, 1, 0, 0));
    step(6);

    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s never_checked due=%0d", sb[i].tag, sb[i].due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1);
  end

endmodule
